// File: rtl/fpga_ram_pkg.sv
// Shared types and constants for the req/gnt to single-port SRAM bank initiator.
package fpga_ram_pkg;

  localparam logic [3:0] BE_ALL           = 4'hF;
  localparam int         MAX_READ_LATENCY = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        is_write;
  } resp_t;

  typedef struct packed {
    logic valid;
    logic is_write;
  } pipe_t;

endpackage

// File: rtl/fpga_resp_fifo.sv
// Response FIFO with a registered storage array; the head entry is read straight from it.
module fpga_resp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 33,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;

  // Storage is cleared on reset so no stale entry can surface afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop_ok) rptr_q <= ptr_inc(rptr_q);
      case ({push_i, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fpga_ram_initiator.sv
// Bridges a req/gnt/rvalid/rready port onto one private SRAM bank with fixed read latency,
// keeping every response in order and buffered so the consumer may stall.
module fpga_ram_initiator
  import fpga_ram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  wen_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [31:0]           rdata_o,
  output logic                  mem_csn_o,
  output logic                  mem_wen_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  localparam int CW = $clog2(RESP_DEPTH + 1);

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY ||
      RESP_DEPTH < READ_LATENCY + 2) begin : g_param_err
    $error("fpga_ram_initiator: illegal READ_LATENCY/RESP_DEPTH combination");
  end

  logic                  init_q;
  logic [CW-1:0]         out_q, out_d;
  pipe_t [READ_LATENCY:1] pipe_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  pop, push;
  resp_t                 push_data, head;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;

  // The outstanding cap bounds FIFO occupancy, so the FIFO itself never needs overflow protection.
  assign gnt_o = req_i & init_q & (out_q < CW'(RESP_DEPTH));
  assign pop   = rvalid_o & rready_i;

  always_comb begin
    mem_csn_o   = ~gnt_o;
    mem_wen_o   = 1'b1;
    mem_be_o    = '0;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    if (gnt_o) begin
      mem_wen_o   = wen_i;
      mem_be_o    = wen_i ? BE_ALL : be_i;
      mem_addr_o  = addr_i;
      mem_wdata_o = wdata_i;
    end
  end

  always_comb begin
    out_d = out_q;
    case ({gnt_o, pop})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q  <= 1'b0;
      out_q   <= '0;
      pipe_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      init_q    <= 1'b1;
      out_q     <= out_d;
      pipe_q[1] <= '{valid: gnt_o, is_write: ~wen_i};
      for (int i = 2; i <= READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      if (gnt_o) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  end

  assign push      = pipe_q[READ_LATENCY].valid;
  assign push_data = '{rdata:    pipe_q[READ_LATENCY].is_write ? 32'h0 : mem_rdata_i,
                       is_write: pipe_q[READ_LATENCY].is_write};

  fpga_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH ($bits(resp_t))
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rvalid_o = ~fifo_empty;
  assign rdata_o  = (rvalid_o & ~head.is_write) ? head.rdata : 32'h0;

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full));
  a_cnt_bounded:  assert property (@(posedge clk_i) disable iff (!rst_ni) fifo_count <= out_q);

endmodule

// File: tb/tb_fpga_ram_initiator.sv
// Scoreboard bench: two initiators (read latency 1 and 2) each driving a behavioural SRAM bank.
module tb_fpga_ram_initiator;

  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  // DUT A: READ_LATENCY=1
  logic          reqa = 0, wena = 1, rreadya = 1;
  logic [3:0]    bea = 0;
  logic [AW-1:0] addra = 0;
  logic [31:0]   wdataa = 0;
  logic          gnta, rvalida, csna, mwena;
  logic [31:0]   rdataa, mwdataa, mrdataa;
  logic [3:0]    mbea;
  logic [AW-1:0] maddra;

  // DUT B: READ_LATENCY=2
  logic          reqb = 0, wenb = 1, rreadyb = 1;
  logic [3:0]    beb = 0;
  logic [AW-1:0] addrb = 0;
  logic [31:0]   wdatab = 0;
  logic          gntb, rvalidb, csnb, mwenb;
  logic [31:0]   rdatab, mwdatab, mrdatab, rdb1;
  logic [3:0]    mbeb;
  logic [AW-1:0] maddrb;

  logic [31:0] banka [64];
  logic [31:0] bankb [64];

  fpga_ram_initiator #(.ADDR_WIDTH(AW), .READ_LATENCY(1), .RESP_DEPTH(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(reqa), .gnt_o(gnta), .addr_i(addra), .wen_i(wena),
    .be_i(bea), .wdata_i(wdataa), .rvalid_o(rvalida), .rready_i(rreadya), .rdata_o(rdataa),
    .mem_csn_o(csna), .mem_wen_o(mwena), .mem_be_o(mbea), .mem_addr_o(maddra),
    .mem_wdata_o(mwdataa), .mem_rdata_i(mrdataa)
  );

  fpga_ram_initiator #(.ADDR_WIDTH(AW), .READ_LATENCY(2), .RESP_DEPTH(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(reqb), .gnt_o(gntb), .addr_i(addrb), .wen_i(wenb),
    .be_i(beb), .wdata_i(wdatab), .rvalid_o(rvalidb), .rready_i(rreadyb), .rdata_o(rdatab),
    .mem_csn_o(csnb), .mem_wen_o(mwenb), .mem_be_o(mbeb), .mem_addr_o(maddrb),
    .mem_wdata_o(mwdatab), .mem_rdata_i(mrdatab)
  );

  // Bank A: contents = address for 0..15, 0xDEADBEEF at 0x010, zero elsewhere.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) banka[i] <= (i < 16) ? 32'(i) : 32'h0;
      banka[16] <= 32'hDEADBEEF;
      mrdataa   <= 32'h0;
    end else if (!csna) begin
      if (!mwena) begin
        for (int b = 0; b < 4; b++)
          if (mbea[b]) banka[maddra[5:0]][8*b +: 8] <= mwdataa[8*b +: 8];
      end else begin
        mrdataa <= banka[maddra[5:0]];
      end
    end
  end

  // Bank B: contents = 3*addr+1, two-cycle read.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) bankb[i] <= 32'(3 * i + 1);
      rdb1    <= 32'h0;
      mrdatab <= 32'h0;
    end else begin
      if (!csnb && mwenb) rdb1 <= bankb[maddrb[5:0]];
      mrdatab <= rdb1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && rvalida && rreadya) begin
      if (qa.size() == 0) begin
        n_chk++;
        $display("FAIL a_unexpected_resp: got %h expected no response", rdataa);
      end else begin
        ea = qa.pop_front();
        chk("a_rdata", rdataa, ea.d);
        if (ea.due >= 0) chk("a_latency", cyc, ea.due);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rvalidb && rreadyb) begin
      if (qb.size() == 0) begin
        n_chk++;
        $display("FAIL b_unexpected_resp: got %h expected no response", rdatab);
      end else begin
        eb = qb.pop_front();
        chk("b_rdata", rdatab, eb.d);
        if (eb.due >= 0) chk("b_latency", cyc, eb.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic w, input logic [AW-1:0] a, input logic [3:0] b,
                         input logic [31:0] wd);
    reqa = 1'b1; wena = w; addra = a; bea = b; wdataa = wd;
  endtask

  task automatic drain_a(input string nm);
    int n = 0;
    while (qa.size() != 0 && n < 50) begin @(posedge clk); n++; end
    #1;
    chk(nm, qa.size(), 0);
  endtask

  task automatic drain_b(input string nm);
    int n = 0;
    while (qb.size() != 0 && n < 50) begin @(posedge clk); n++; end
    #1;
    chk(nm, qb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp6 [6] = '{32'd1, 32'd4, 32'd7, 32'd10, 32'd13, 32'd16};

  initial begin
    int ng, k, seen;

    // Reset state, with requests asserted to show gnt is held off
    reqa = 1; reqb = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt_a", gnta, 0);
    chk("rst_gnt_b", gntb, 0);
    chk("rst_rvalid", rvalida, 0);
    chk("rst_rdata", rdataa, 0);
    chk("rst_csn", csna, 1);
    @(posedge clk); #1;
    rst_n = 1; reqa = 0; reqb = 0;
    tick();

    // Test 1: single read of 0x010
    tick();
    drive_a(1, 12'h010, 4'h0, 32'h0);
    @(negedge clk);
    chk("t1_gnt", gnta, 1);
    chk("t1_csn", csna, 0);
    chk("t1_be", mbea, 4'hF);
    if (gnta) qa.push_back('{d: 32'hDEADBEEF, due: cyc + 2});
    tick();
    reqa = 0;
    @(negedge clk);
    chk("t1_csn_idle", csna, 1);
    chk("t1_be_idle", mbea, 4'h0);
    tick();
    drain_a("t1_drain");

    // Test 2: partial write then read back
    tick();
    drive_a(0, 12'h020, 4'b0011, 32'h12345678);
    @(negedge clk);
    chk("t2_wr_gnt", gnta, 1);
    chk("t2_wen", mwena, 0);
    chk("t2_be", mbea, 4'b0011);
    if (gnta) qa.push_back('{d: 32'h0, due: cyc + 2});
    tick();
    drive_a(1, 12'h020, 4'h0, 32'h0);
    @(negedge clk);
    chk("t2_rd_gnt", gnta, 1);
    if (gnta) qa.push_back('{d: 32'h00005678, due: cyc + 2});
    tick();
    reqa = 0;
    drain_a("t2_drain");

    // Test 3: eight back-to-back reads
    tick();
    ng = 0;
    for (int i = 0; i < 8; i++) begin
      drive_a(1, AW'(i), 4'h0, 32'h0);
      @(negedge clk);
      if (gnta) begin qa.push_back('{d: 32'(i), due: cyc + 2}); ng++; end
      tick();
    end
    reqa = 0;
    chk("t3_grants", ng, 8);
    drain_a("t3_drain");

    // Test 4: backpressure then release
    tick();
    rreadya = 0; k = 0; ng = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 10) rreadya = 1;
      drive_a(1, AW'(k), 4'h0, 32'h0);
      @(negedge clk);
      if (c == 9) begin
        chk("t4_grants_stalled", ng, 4);
        chk("t4_gnt_blocked", gnta, 0);
        chk("t4_rvalid_held", rvalida, 1);
      end
      if (c == 10) chk("t4_gnt_at_first_pop", gnta, 0);
      if (c == 11) chk("t4_gnt_after_pop", gnta, 1);
      if (gnta) begin qa.push_back('{d: 32'(k), due: -1}); k++; ng++; end
      tick();
    end
    reqa = 0;
    chk("t4_total_grants", ng, 9);
    drain_a("t4_drain");

    // Test 5: reset with two responses buffered
    tick();
    rreadya = 0;
    drive_a(1, 12'h003, 4'h0, 32'h0);
    @(negedge clk);
    if (gnta) qa.push_back('{d: 32'd3, due: -1});
    tick();
    drive_a(1, 12'h004, 4'h0, 32'h0);
    @(negedge clk);
    if (gnta) qa.push_back('{d: 32'd4, due: -1});
    tick();
    reqa = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("t5_rvalid_buffered", rvalida, 1);
    #2;
    rst_n = 0;
    #1;
    chk("t5_rvalid_async", rvalida, 0);
    chk("t5_rdata_async", rdataa, 0);
    qa.delete();
    tick();
    tick();
    rst_n = 1;
    rreadya = 1;
    drive_a(1, 12'h005, 4'h0, 32'h0);
    @(negedge clk);
    chk("t5_gnt_after_release", gnta, 0);
    tick();
    reqa = 0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (rvalida) seen++; end
    chk("t5_no_stale", seen, 0);
    tick();

    // Test 6: READ_LATENCY=2 single read and streaming
    reqb = 1; addrb = 12'h005;
    @(negedge clk);
    chk("t6_gnt", gntb, 1);
    if (gntb) qb.push_back('{d: 32'd16, due: cyc + 3});
    tick();
    reqb = 0;
    drain_b("t6_single_drain");
    tick();
    ng = 0;
    for (int i = 0; i < 6; i++) begin
      reqb = 1; addrb = AW'(i);
      @(negedge clk);
      if (gntb) begin qb.push_back('{d: exp6[i], due: cyc + 3}); ng++; end
      tick();
    end
    reqb = 0;
    chk("t6_stream_grants", ng, 6);
    drain_b("t6_stream_drain");

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fpga_ram_initiator.md
Name: fpga_ram_initiator

Overview:
- Initiator-side bridge that turns a req/gnt/rvalid/rready bus into the single-port SRAM bank interface of the L2 private banks: csn, active-low wen, byte enables, word address, wdata and rdata with a fixed read latency.
- Tracks outstanding transactions, aligns returning bank data to its request, and buffers responses so the consumer may stall without losing data.
- Sits between the interconnect port and one private RAM bank instance.

Parameters:
- ADDR_WIDTH, 12, bank word-address width.
- READ_LATENCY, 1, cycles from bank select to valid mem_rdata_i; legal values 1..2.
- RESP_DEPTH, 4, maximum outstanding transactions and response buffer depth; must be >= READ_LATENCY+2 (elaboration assertion).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  ADDR_WIDTH  word address.
- wen_i  in  1  0 = write, 1 = read.
- be_i  in  4  byte enables.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid.
- rready_i  in  1  consumer accepts response.
- rdata_o  out  32  read data; 0 for write responses.
- mem_csn_o  out  1  bank select, active low.
- mem_wen_o  out  1  bank write enable, active low.
- mem_be_o  out  4  bank byte enables.
- mem_addr_o  out  ADDR_WIDTH  bank address.
- mem_wdata_o  out  32  bank write data.
- mem_rdata_i  in  32  bank read data.

Interface note: one clock; reset is asynchronous and active-low, named clk_i and rst_ni.

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, mem_csn_o=1. Outstanding counter, latency pipe, response FIFO and init flag are all cleared.
- Init flag: cleared by reset and set on the first clk_i edge after rst_ni rises. gnt_o stays 0 until the flag is set.
- Grant rule: gnt_o = req_i & init & (outstanding < RESP_DEPTH). This is combinational, with no rready_i→gnt_o path.
- Bank drive on grant (same cycle, combinational):
  - mem_csn_o=0, mem_wen_o=wen_i, mem_addr_o=addr_i, mem_wdata_o=wdata_i.
  - mem_be_o=be_i for writes, 4'hF for reads.
- Bank drive with no grant: mem_csn_o=1, mem_wen_o=1, mem_be_o=0. Address and data are don't-care but must be stable (hold the last value).
- Latency pipe: a READ_LATENCY-deep shift register of {valid, is_write}. When an entry reaches stage READ_LATENCY, push into the FIFO on that clock edge:
  - reads push mem_rdata_i;
  - writes push 0.
- Every granted transaction, read or write, produces exactly one response, in order.
- Response FIFO: RESP_DEPTH entries with registered head.
  - rvalid_o = FIFO non-empty.
  - rdata_o = head entry when rvalid_o=1, else 0.
  - Pop when rvalid_o & rready_i.
- Latency: grant at cycle t gives rvalid_o at t+READ_LATENCY+1 if the FIFO is empty and not stalled.
- Outstanding counter, width $clog2(RESP_DEPTH+1):
  - +1 on grant, −1 on pop;
  - grant and pop in the same cycle leaves it unchanged.
  - Because grants stop at RESP_DEPTH, the FIFO cannot overflow (no overflow path needed).
- Throughput: with rready_i=1 held, one grant per cycle indefinitely.
- Backpressure: with rready_i=0, exactly RESP_DEPTH grants, then gnt_o=0. The first pop re-enables grant on the following cycle.
- FIFO pointers wrap modulo RESP_DEPTH. Push and pop in the same cycle on a full FIFO is impossible. Push and pop in the same cycle on an empty FIFO is impossible because output is registered.
- Reset mid-operation: all in-flight and buffered responses are discarded. rvalid_o drops asynchronously. Nothing stale appears after release.

Decomposition:
- Package fpga_ram_pkg:
  - resp_t struct {rdata[31:0], is_write};
  - pipe_t struct {valid, is_write};
  - constants BE_ALL=4'hF, MAX_READ_LATENCY=2.
- Sub-module fpga_resp_fifo: parameterised depth, registered head, push/pop/full/empty/count.

Test Plan:
1. Bank preloaded 0xDEADBEEF at 0x010, READ_LATENCY=1, single read at cycle t -> gnt_o=1 at t; mem_csn_o=0 and mem_be_o=4'hF at t only; rvalid_o=1 with rdata_o=0xDEADBEEF at t+2.
2. Write 0x12345678, be 4'b0011 to 0x020 (bank zeroed), then read 0x020 -> mem_wen_o=0 and mem_be_o=4'b0011 during the write; write response rdata_o=0; read response rdata_o=0x00005678.
3. 8 back-to-back reads of 0x000..0x007 (contents = address), rready_i=1 -> gnt_o high 8 consecutive cycles; 8 in-order responses 0..7 on consecutive cycles.
4. Continuous req_i with rready_i=0 -> exactly 4 grants, then gnt_o=0 and the counter holds at 4; raise rready_i -> one pop per cycle, gnt_o returns the cycle after the first pop, and no response is lost or duplicated.
5. rst_ni pulsed low with 2 responses buffered -> rvalid_o=0 immediately; after release, gnt_o=0 in the first cycle even with req_i=1; no stale rvalid_o.
6. READ_LATENCY=2, RESP_DEPTH=4 build, single read at t -> rvalid_o at t+3 with the correct data; streaming reads still achieve 1 grant per cycle.
